// File: rtl/seq_gen_tx_if.sv
// Bundle of the frame request and serial output signals of seq_gen_tx.
// The master side issues frame requests and watches the serial stream;
// the slave side is the frame generator itself.
interface seq_gen_tx_if #(
   parameter int DATA_W = 8
);
   logic              start;
   logic [DATA_W-1:0] data;
   logic              tx;
   logic              valid;
   logic              busy;
   logic              done;
   logic [2:0]        state;

   modport master (
      output start,
      output data,
      input  tx,
      input  valid,
      input  busy,
      input  done,
      input  state
   );

   modport slave (
      input  start,
      input  data,
      output tx,
      output valid,
      output busy,
      output done,
      output state
   );
endinterface

// File: rtl/seq_gen_tx.sv
// Serial frame generator: sync word 1101, then the payload MSB first, then
// an optional even-parity bit, one bit per clock.
// Compile-time option: define SEQ_GEN_PARITY_EN to append the parity bit.
// Every output is registered; the registers hold the bit shown in the current
// cycle, and the combinational block works out the bit for the next cycle.
module seq_gen_tx #(
   parameter int DATA_W = 8
) (
   input  logic         clk,
   input  logic         rst,
   seq_gen_tx_if.slave  bus
);

   localparam int CNT_MAX = (DATA_W > 4) ? DATA_W : 4;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(3);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SYNC = 3'd1,
      DATA = 3'd2,
      PAR  = 3'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              tx_q, tx_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
`ifdef SEQ_GEN_PARITY_EN
   logic              parity_q, parity_d;
`endif

   // State, counter, payload and output registers; reset aborts any frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         shreg_q  <= '0;
         tx_q     <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shreg_q  <= shreg_d;
         tx_q     <= tx_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef SEQ_GEN_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   // Next state and the bit to present in the next cycle; the payload is
   // captured only on the accepting edge and consumed MSB first by shifting.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shreg_d  = shreg_q;
      tx_d     = 1'b0;
      valid_d  = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      parity_d = parity_q;
`endif

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d  = SYNC;
               cnt_d    = '0;
               shreg_d  = bus.data;
`ifdef SEQ_GEN_PARITY_EN
               parity_d = ^bus.data;
`endif
               tx_d     = 1'b1;
               valid_d  = 1'b1;
               busy_d   = 1'b1;
            end
         end

         SYNC: begin
            valid_d = 1'b1;
            busy_d  = 1'b1;
            if (cnt_q == SYNC_LAST) begin
               state_d = DATA;
               cnt_d   = '0;
               tx_d    = shreg_q[DATA_W-1];
               shreg_d = shreg_q << 1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               tx_d  = (cnt_q != CNT_W'(1));
            end
         end

         DATA: begin
            if (cnt_q == DATA_LAST) begin
               cnt_d = '0;
`ifdef SEQ_GEN_PARITY_EN
               state_d = PAR;
               tx_d    = parity_q;
               valid_d = 1'b1;
               busy_d  = 1'b1;
`else
               state_d = IDLE;
               done_d  = 1'b1;
`endif
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               tx_d    = shreg_q[DATA_W-1];
               shreg_d = shreg_q << 1;
               valid_d = 1'b1;
               busy_d  = 1'b1;
            end
         end

`ifdef SEQ_GEN_PARITY_EN
         PAR: begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
         end
`endif

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
         end
      endcase
   end

   assign bus.tx    = tx_q;
   assign bus.valid = valid_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.state = state_q;

endmodule
